// File: rtl/fetch_stage_if.sv
// Fetch-side bus: instruction ROM port plus the decoder handoff (instruction out, jump request in).
interface fetch_stage_if #(
    parameter int unsigned D = 12,
    parameter int unsigned W = 9
);
    logic [D-1:0] imem_addr;
    logic [W-1:0] imem_data;
    logic [W-1:0] instr;
    logic [D-1:0] instr_pc;
    logic         instr_valid;
    logic         absjump_en;
    logic [D-1:0] target;

    modport master (
        output imem_addr, instr, instr_pc, instr_valid,
        input  imem_data, absjump_en, target
    );

    modport slave (
        input  imem_addr, instr, instr_pc, instr_valid,
        output imem_data, absjump_en, target
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a one-cycle-latency ROM and hands registered
// machine code to the decoder, with stall, absolute jump/squash and start/done sequencing.
module fetch_stage #(
    parameter int unsigned D        = 12,
    parameter int unsigned W        = 9,
    parameter int unsigned PROG_LEN = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           stall,
    output logic           busy,
    output logic           done,
    fetch_stage_if.master  bus
);
    localparam logic [D:0]   LEN  = (D+1)'(PROG_LEN);
    localparam logic [D-1:0] LAST = D'(PROG_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t       state_q, state_n;
    logic [D-1:0] f_q, f_n;
    logic [D-1:0] pend_pc_q, pend_pc_n;
    logic         pend_valid_q, pend_valid_n;
    logic [W-1:0] instr_q, instr_n;
    logic [D-1:0] instr_pc_q, instr_pc_n;
    logic         instr_valid_q, instr_valid_n;
    logic         done_q, done_n;
    logic         active, jump, target_oob;
    logic [D-1:0] addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            f_q           <= '0;
            pend_pc_q     <= '0;
            pend_valid_q  <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_n;
            f_q           <= f_n;
            pend_pc_q     <= pend_pc_n;
            pend_valid_q  <= pend_valid_n;
            instr_q       <= instr_n;
            instr_pc_q    <= instr_pc_n;
            instr_valid_q <= instr_valid_n;
            done_q        <= done_n;
        end
    end

    // Next-state, datapath and ROM address selection
    always_comb begin
        state_n       = state_q;
        f_n           = f_q;
        pend_pc_n     = pend_pc_q;
        pend_valid_n  = pend_valid_q;
        instr_n       = instr_q;
        instr_pc_n    = instr_pc_q;
        instr_valid_n = instr_valid_q;
        done_n        = done_q;

        active     = (state_q == S_RUN) || (state_q == S_DRAIN);
        jump       = active && bus.absjump_en && instr_valid_q && !stall;
        target_oob = {1'b0, bus.target} >= LEN;

        // Start from IDLE/DONE must fetch address 0 regardless of where F was left
        if (!active)   addr = start ? '0 : f_q;
        else if (jump) addr = bus.target;
        else if (stall) addr = pend_pc_q;
        else           addr = f_q;

        if (!active) begin
            if (start) begin
                pend_pc_n    = '0;
                pend_valid_n = 1'b1;
                f_n          = D'(1);
                done_n       = 1'b0;
                state_n      = S_RUN;
            end
        end else if (jump) begin
            instr_n       = bus.imem_data;
            instr_pc_n    = pend_pc_q;
            instr_valid_n = 1'b0;
            pend_pc_n     = bus.target;
            f_n           = bus.target + D'(1);
            if (target_oob) begin
                pend_valid_n = 1'b0;
                done_n       = 1'b1;
                state_n      = S_DONE;
            end else begin
                pend_valid_n = 1'b1;
                state_n      = S_RUN;
            end
        end else if (!stall) begin
            instr_n       = bus.imem_data;
            instr_pc_n    = pend_pc_q;
            instr_valid_n = pend_valid_q;
            pend_pc_n     = f_q;
            pend_valid_n  = {1'b0, f_q} < LEN;
            f_n           = f_q + D'(1);
            if (state_q == S_DRAIN) begin
                instr_valid_n = 1'b0;
                done_n        = 1'b1;
                state_n       = S_DONE;
            end else if (pend_valid_q && (pend_pc_q == LAST)) begin
                state_n = S_DRAIN;
            end
        end
    end

    assign bus.imem_addr   = addr;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done            = done_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall, jump/squash, drain/done, restart, reset abort.
module tb_fetch_stage;
    localparam int unsigned D = 12;
    localparam int unsigned W = 9;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic stall;
    logic busy;
    logic done;
    int   checks   = 0;
    int   failures = 0;

    fetch_stage_if #(.D(D), .W(W)) bus ();

    fetch_stage #(.D(D), .W(W), .PROG_LEN(128)) dut (
        .clk   (clk),
        .reset (rst_n),
        .start (start),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Bijective ROM contents so instr cannot alias instr_pc
    function automatic logic [W-1:0] rom_val(input logic [D-1:0] a);
        return W'(a * 12'd7 + 12'd3);
    endfunction

    always @(posedge clk) bus.imem_data <= rom_val(bus.imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stall = 1'b0;
        bus.absjump_en = 1'b0; bus.target = '0;
        #12;
        checks++;
        if (bus.instr !== '0 || bus.instr_pc !== '0 || bus.instr_valid !== 1'b0 ||
            busy !== 1'b0 || done !== 1'b0 || bus.imem_addr !== '0) begin
            failures++;
            $display("FAIL reset instr=%0d pc=%0d valid=%b busy=%b done=%b addr=%0d, all required 0",
                     bus.instr, bus.instr_pc, bus.instr_valid, busy, done, bus.imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_start_and_stall();
        start = 1'b1; stall = 1'b1;
        tick();
        start = 1'b0; stall = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_edge busy=%b valid=%b, required busy=1 valid=0", busy, bus.instr_valid);
        end
        for (int k = 0; k <= 5; k++) begin
            tick();
            checks++;
            if (bus.instr_pc !== D'(k) || bus.instr !== rom_val(D'(k)) || bus.instr_valid !== 1'b1) begin
                failures++;
                $display("FAIL seq pc=%0d instr=%0d valid=%b, required pc=%0d instr=%0d valid=1",
                         bus.instr_pc, bus.instr, bus.instr_valid, k, rom_val(D'(k)));
            end
        end
        stall = 1'b1;
        #1;
        checks++;
        if (bus.imem_addr !== D'(6)) begin
            failures++;
            $display("FAIL stall_addr addr=%0d, required 6", bus.imem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.instr_pc !== D'(5) || bus.instr !== rom_val(D'(5)) || bus.instr_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold pc=%0d instr=%0d valid=%b, required pc=5 valid=1",
                         bus.instr_pc, bus.instr, bus.instr_valid);
            end
        end
        stall = 1'b0;
        for (int k = 6; k <= 10; k++) begin
            tick();
            checks++;
            if (bus.instr_pc !== D'(k) || bus.instr !== rom_val(D'(k)) || bus.instr_valid !== 1'b1) begin
                failures++;
                $display("FAIL post_stall pc=%0d instr=%0d valid=%b, required pc=%0d instr=%0d",
                         bus.instr_pc, bus.instr, bus.instr_valid, k, rom_val(D'(k)));
            end
        end
    endtask

    task automatic test_jump();
        bus.absjump_en = 1'b1; bus.target = D'(40);
        #1;
        checks++;
        if (bus.imem_addr !== D'(40)) begin
            failures++;
            $display("FAIL jump_addr addr=%0d, required 40", bus.imem_addr);
        end
        tick();
        bus.absjump_en = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL jump_bubble valid=%b busy=%b, required valid=0 busy=1", bus.instr_valid, busy);
        end
        for (int k = 40; k <= 41; k++) begin
            tick();
            checks++;
            if (bus.instr_pc !== D'(k) || bus.instr !== rom_val(D'(k)) || bus.instr_valid !== 1'b1) begin
                failures++;
                $display("FAIL jump_target pc=%0d instr=%0d valid=%b, required pc=%0d instr=%0d",
                         bus.instr_pc, bus.instr, bus.instr_valid, k, rom_val(D'(k)));
            end
        end
        // Stall wins over a simultaneous jump request
        stall = 1'b1; bus.absjump_en = 1'b1; bus.target = D'(20);
        tick();
        stall = 1'b0;
        checks++;
        if (bus.instr_pc !== D'(41) || bus.instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_jump_hold pc=%0d valid=%b, required pc=41 valid=1", bus.instr_pc, bus.instr_valid);
        end
        tick();
        bus.absjump_en = 1'b0;
        checks++;
        if (bus.instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_jump_bubble valid=%b, required 0", bus.instr_valid);
        end
    endtask

    task automatic test_drain();
        for (int k = 20; k <= 127; k++) begin
            tick();
            checks++;
            if (bus.instr_pc !== D'(k) || bus.instr !== rom_val(D'(k)) ||
                bus.instr_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL run pc=%0d instr=%0d valid=%b busy=%b done=%b, required pc=%0d instr=%0d valid=1 busy=1 done=0",
                         bus.instr_pc, bus.instr, bus.instr_valid, busy, done, k, rom_val(D'(k)));
            end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (done !== 1'b1 || bus.instr_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL drain_done done=%b valid=%b busy=%b, required done=1 valid=0 busy=0",
                         done, bus.instr_valid, busy);
            end
        end
    endtask

    task automatic test_restart_and_oob_jump();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL restart done=%b busy=%b, required done=0 busy=1", done, busy);
        end
        for (int k = 0; k <= 3; k++) begin
            tick();
            checks++;
            if (bus.instr_pc !== D'(k) || bus.instr !== rom_val(D'(k)) || bus.instr_valid !== 1'b1) begin
                failures++;
                $display("FAIL restart_seq pc=%0d instr=%0d valid=%b, required pc=%0d instr=%0d",
                         bus.instr_pc, bus.instr, bus.instr_valid, k, rom_val(D'(k)));
            end
        end
        bus.absjump_en = 1'b1; bus.target = D'(200);
        tick();
        bus.absjump_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (done !== 1'b1 || bus.instr_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL oob_jump done=%b valid=%b busy=%b, required done=1 valid=0 busy=0",
                         done, bus.instr_valid, busy);
            end
            tick();
        end
    endtask

    task automatic test_reset_midrun();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 60; k++) tick();
        checks++;
        if (bus.instr_pc !== D'(60) || bus.instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL pre_abort pc=%0d valid=%b, required pc=60 valid=1", bus.instr_pc, bus.instr_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.instr_valid !== 1'b0 || busy !== 1'b0 || bus.imem_addr !== '0 || done !== 1'b0) begin
            failures++;
            $display("FAIL async_abort valid=%b busy=%b addr=%0d done=%b, required all 0",
                     bus.instr_valid, busy, bus.imem_addr, done);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (bus.instr_valid !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_after_abort valid=%b busy=%b, required 0", bus.instr_valid, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_and_stall();
        test_jump();
        test_drain();
        test_restart_and_oob_jump();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage that sits directly upstream of the control decoder. It owns the program counter and issues addresses to a synchronous instruction ROM. It presents registered 9-bit machine code to the decoder together with its PC and a valid bit, and handles stalls, absolute jumps with squash, and program start/done sequencing. The decoder's branch output feeds back as `absjump_en`/`target`.

## Interface
- `D`, 12, program counter / ROM address width
- `W`, 9, machine-code width
- `PROG_LEN`, 128, program length in instructions; legal addresses 0..PROG_LEN-1; must be ≤ 2^D

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  launch program at address 0 (sampled in IDLE/DONE only)
- `stall`  in  1  hold all fetch state and outputs this cycle
- `absjump_en`  in  1  decoder requests jump for the currently presented instruction
- `target`  in  D  absolute jump address
- `imem_addr`  out  D  ROM address; ROM returns data one cycle later
- `imem_data`  in  W  ROM data for the address presented the previous cycle
- `instr`  out  W  registered machine code to decoder
- `instr_pc`  out  D  address of `instr`
- `instr_valid`  out  1  `instr` is a live instruction
- `busy`  out  1  state is RUN or DRAIN
- `done`  out  1  program finished; held until next `start`

## Operation
- Registers: F (next fetch address), pend_pc/pend_valid (request in flight), output regs `instr`/`instr_pc`/`instr_valid`, state.
- FSM states: IDLE, RUN, DRAIN, DONE.
- `imem_addr` is combinational:
  - `target` if a jump is taken this cycle;
  - otherwise pend_pc if `stall`;
  - otherwise F.
- Advance cycle (RUN or DRAIN, `stall`=0):
  - outputs load {`imem_data`, pend_pc, pend_valid};
  - pend_pc←F; pend_valid←(F < PROG_LEN); F←F+1 (mod 2^D).
- Stall: every register holds. `imem_addr`=pend_pc, so the cycle after release still sees ROM data for pend_pc.
- Jump taken = `absjump_en` & `instr_valid` & !`stall` in RUN or DRAIN. On a jump:
  - `instr_valid`←0, squashing the fall-through instruction;
  - pend_pc←`target`; pend_valid←1; F←`target`+1; state←RUN.
  - If `target` ≥ PROG_LEN: pend_valid←0, `done`←1, state←DONE.
- `absjump_en` is ignored when `instr_valid`=0 or `stall`=1.
- IDLE/DONE + `start`: pend_pc←0, pend_valid←1, F←1, `done`←0, state←RUN. `start` is ignored in RUN/DRAIN.
- RUN→DRAIN: on an advance cycle that loads a valid instruction with pend_pc = PROG_LEN-1.
- DRAIN, advance cycle with no jump: `instr_valid`←0, `done`←1, state←DONE.
- `busy` = (state ∈ {RUN, DRAIN}), decoded from state.
- Addresses ≥ PROG_LEN may appear on `imem_addr`, but their data is never marked valid.

## Timing
- Reset (async, `reset`=0):
  - state=IDLE; F=0, pend_pc=0, pend_valid=0;
  - `instr`=0, `instr_pc`=0, `instr_valid`=0, `done`=0, `busy`=0;
  - `imem_addr`=0.
- Reset asserted mid-program aborts immediately, with no drain.
- Start latency: `start` high at edge t → at edge t+1 `instr`=mem[0], `instr_pc`=0, `instr_valid`=1.
- Steady state: one instruction per unstalled cycle; PC increments by 1.
- Jump penalty: exactly one bubble (`instr_valid`=0). At the second edge after the jump cycle, `instr`=mem[target].
- `stall` for N cycles holds outputs N cycles. The first unstalled edge delivers the next sequential instruction with no loss or duplication.
- Stall and `absjump_en` in the same cycle: stall wins; the decoder must hold `absjump_en` until the stall is released.
- `done` rises at the first unstalled edge after instruction PROG_LEN-1 has been presented. `instr_valid` falls on the same edge.
- `start` and `stall` together in IDLE: start wins; stall only affects RUN/DRAIN.

## Test plan
- Reset low, then release; pulse `start`; ROM mem[i]=i. Required: `instr`/`instr_pc` = 0,1,2,… on consecutive cycles, `instr_valid`=1, `busy`=1.
- At `instr_pc`=5, assert `stall` for 3 cycles. Required: outputs hold pc 5 for 4 edges total, then pc 6, 7; no skipped or duplicated pc.
- At `instr_pc`=10, pulse `absjump_en`, `target`=40. Required: next edge `instr_valid`=0 (pc 11 squashed), then pc 40, 41 valid.
- PROG_LEN=128, run straight through. Required: last valid pc 127; next edge `done`=1, `instr_valid`=0, `busy`=0. `done` holds until `start`; a second `start` restarts at pc 0 with `done`=0.
- Jump with `target`=200 (≥ PROG_LEN). Required: next edge `done`=1, no valid instruction issued.
- Assert `reset` low mid-run at pc 60. Required: asynchronously `instr_valid`=0, `busy`=0, `imem_addr`=0, state IDLE; no output until the next `start`.
